// File: rtl/wave_phase_sequencer.sv
// wave_phase_sequencer
//   Phase source for the waveform processor. Produces the CNT_W-bit phase
//   ramp `cnt`, advanced once per prescaler tick (every div_act+1 clocks),
//   and the committed waveform select `sel`. Divisor and select requests
//   are staged continuously and only committed at start or at a period
//   boundary, so a period in progress never changes shape or rate.
//
// Ports
//   clk      system clock, rising edge
//   rst      asynchronous reset, active low
//   start    level run request
//   stop     level stop request (current period is finished first)
//   div_ld   strobe: div_in -> pending divisor
//   div_in   requested divisor (tick period = div_in+1 clocks)
//   sel_in   requested waveform select, staged every cycle
//   cnt      phase ramp
//   sel      committed waveform select
//   wrap     one-cycle pulse while cnt sits at 0 after a 255->0 tick
//   running  high in RUN and DRAIN
module wave_phase_sequencer #(
    parameter int CNT_W = 8,
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             div_ld,
    input  logic [DIV_W-1:0] div_in,
    input  logic [2:0]       sel_in,
    output logic [CNT_W-1:0] cnt,
    output logic [2:0]       sel,
    output logic             wrap,
    output logic             running
);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = 1;
    localparam logic [DIV_W-1:0] DIV_ONE = 1;

    state_t           state;
    logic [DIV_W-1:0] presc;
    logic [DIV_W-1:0] div_act;
    logic [DIV_W-1:0] div_pend;
    logic [2:0]       sel_pend;

    logic tick;
    logic wrap_tick;

    // A tick is the prescaler rolling over; the wrap tick is the one that
    // carries cnt from all-ones back to zero (the period boundary).
    assign tick      = (state != IDLE) && (presc == div_act);
    assign wrap_tick = tick && (cnt == '1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= '0;
            presc    <= '0;
            div_act  <= '0;
            div_pend <= '0;
            sel      <= '0;
            sel_pend <= '0;
            wrap     <= 1'b0;
            running  <= 1'b0;
        end else begin
            // Staging runs in every state; commits below read the values
            // held before this edge, so same-cycle requests wait a period.
            sel_pend <= sel_in;
            if (div_ld) div_pend <= div_in;

            wrap <= wrap_tick;

            if (state != IDLE) begin
                if (tick) begin
                    presc <= '0;
                    cnt   <= cnt + CNT_ONE;
                end else begin
                    presc <= presc + DIV_ONE;
                end
            end

            case (state)
                IDLE: begin
                    cnt   <= '0;
                    presc <= '0;
                    if (start && !stop) begin
                        state   <= RUN;
                        running <= 1'b1;
                        div_act <= div_pend;
                        sel     <= sel_pend;
                    end
                end
                RUN: begin
                    if (wrap_tick) begin
                        div_act <= div_pend;
                        sel     <= sel_pend;
                    end
                    if (stop) state <= DRAIN;
                end
                DRAIN: begin
                    // Finishing the period wins over a late start request.
                    if (wrap_tick) begin
                        state   <= IDLE;
                        running <= 1'b0;
                        cnt     <= '0;
                        presc   <= '0;
                    end else if (start && !stop) begin
                        state <= RUN;
                    end
                end
                default: begin
                    state   <= IDLE;
                    running <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wave_phase_sequencer.sv
// Directed bench for wave_phase_sequencer: reset, ramp at div 0, staged
// select/divisor commits, drain and drain-restart, prescale by 4, and
// asynchronous reset mid-period.
module tb_wave_phase_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, stop, div_ld;
    logic [7:0] div_in;
    logic [2:0] sel_in;
    logic [7:0] cnt;
    logic [2:0] sel;
    logic       wrap, running;

    int errors = 0;
    int checks = 0;

    wave_phase_sequencer #(.CNT_W(8), .DIV_W(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .stop    (stop),
        .div_ld  (div_ld),
        .div_in  (div_in),
        .sel_in  (sel_in),
        .cnt     (cnt),
        .sel     (sel),
        .wrap    (wrap),
        .running (running)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_cnt(input int v, input int budget);
        int n;
        n = 0;
        while (cnt != v[7:0] && n < budget) begin
            step();
            n++;
        end
        chk("wait_cnt", cnt, v);
    endtask

    // Steps until wrap is seen; n returns the number of clocks taken.
    task automatic wait_wrap(output int n, input int budget);
        n = 0;
        do begin
            step();
            n++;
        end while (!wrap && n < budget);
        chk("wait_wrap", wrap, 1);
    endtask

    initial begin
        int n;
        rst = 1'b0; start = 1'b0; stop = 1'b0; div_ld = 1'b0;
        div_in = 8'd0; sel_in = 3'd0;

        // Reset state
        step(); step();
        chk("rst_cnt", cnt, 0);
        chk("rst_sel", sel, 0);
        chk("rst_wrap", wrap, 0);
        chk("rst_running", running, 0);
        rst = 1'b1;
        step(); step();
        chk("idle_cnt", cnt, 0);
        chk("idle_running", running, 0);

        // Stop in IDLE is ignored
        stop = 1'b1; step(); stop = 1'b0; step();
        chk("idle_stop_running", running, 0);

        // Stage div 0 and select 3, then start
        div_ld = 1'b1; div_in = 8'd0; sel_in = 3'd3;
        step();
        div_ld = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("start_running", running, 1);
        chk("start_sel", sel, 3);
        chk("start_cnt", cnt, 0);

        // Full ramp at div 0; select request at cnt=10, divisor 1 at cnt=100
        for (int i = 1; i <= 255; i++) begin
            if (i - 1 == 10) sel_in = 3'd5;
            if (i - 1 == 100) begin div_ld = 1'b1; div_in = 8'd1; end
            else div_ld = 1'b0;
            step();
            chk("ramp_cnt", cnt, i);
            chk("ramp_wrap", wrap, 0);
            chk("ramp_sel", sel, 3);
            chk("ramp_running", running, 1);
        end
        // Select change in the cycle of the commit edge waits one period
        sel_in = 3'd7;
        step();
        chk("wrap1_cnt", cnt, 0);
        chk("wrap1_wrap", wrap, 1);
        chk("wrap1_sel", sel, 5);
        chk("wrap1_running", running, 1);

        // Divisor 1 now active: each value held 2 clocks; stage div 0 again
        div_ld = 1'b1; div_in = 8'd0;
        step();
        div_ld = 1'b0;
        chk("div1_cnt_a", cnt, 0);
        chk("div1_wrap_low", wrap, 0);
        step();
        chk("div1_cnt_b", cnt, 1);
        step();
        chk("div1_cnt_c", cnt, 1);
        step();
        chk("div1_cnt_d", cnt, 2);
        chk("div1_sel", sel, 5);
        wait_wrap(n, 600);
        chk("period_div1", n + 4, 512);
        chk("wrap2_sel", sel, 7);
        chk("wrap2_cnt", cnt, 0);
        step();
        chk("div0_again_cnt", cnt, 1);

        // Stop at cnt=200, drain to IDLE
        wait_cnt(200, 300);
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("drain_running", running, 1);
        chk("drain_cnt", cnt, 201);
        wait_cnt(255, 100);
        chk("drain_255_running", running, 1);
        step();
        chk("drain_end_cnt", cnt, 0);
        chk("drain_end_wrap", wrap, 1);
        chk("drain_end_running", running, 0);
        step();
        chk("idle_hold_cnt", cnt, 0);
        chk("idle_hold_wrap", wrap, 0);
        chk("idle_hold_running", running, 0);
        step();
        chk("idle_hold_cnt2", cnt, 0);

        // Restart; stop at 200, start again at 230 during DRAIN
        start = 1'b1;
        step();
        start = 1'b0;
        chk("restart_running", running, 1);
        chk("restart_cnt", cnt, 0);
        step();
        chk("restart_cnt1", cnt, 1);
        wait_cnt(200, 300);
        stop = 1'b1;
        step();
        stop = 1'b0;
        wait_cnt(230, 100);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("rerun_cnt", cnt, 231);
        chk("rerun_running", running, 1);
        wait_cnt(255, 100);
        step();
        chk("rerun_wrap_cnt", cnt, 0);
        chk("rerun_wrap", wrap, 1);
        chk("rerun_wrap_running", running, 1);
        step();
        chk("rerun_cnt_after", cnt, 1);
        chk("rerun_running_after", running, 1);

        // Stop again and stage divisor 3 for the next start
        stop = 1'b1; div_ld = 1'b1; div_in = 8'd3;
        step();
        stop = 1'b0; div_ld = 1'b0;
        wait_wrap(n, 300);
        chk("stop2_cnt", cnt, 0);
        chk("stop2_running", running, 0);

        // Prescale by 4
        start = 1'b1;
        step();
        start = 1'b0;
        chk("div3_running", running, 1);
        chk("div3_sel", sel, 7);
        for (int i = 0; i < 12; i++) begin
            chk("div3_cnt", cnt, i / 4);
            step();
        end
        wait_wrap(n, 1100);
        step();
        chk("div3_wrap_one_clk", wrap, 0);
        chk("div3_cnt_hold0", cnt, 0);
        wait_wrap(n, 1100);
        chk("period_div3", n + 1, 1024);

        // Asynchronous reset between edges
        wait_cnt(77, 400);
        #3;
        rst = 1'b0;
        #1;
        chk("arst_cnt", cnt, 0);
        chk("arst_sel", sel, 0);
        chk("arst_running", running, 0);
        chk("arst_wrap", wrap, 0);
        step();
        rst = 1'b1;
        step(); step(); step();
        chk("post_arst_cnt", cnt, 0);
        chk("post_arst_running", running, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wave_phase_sequencer.md
# wave_phase_sequencer

Upstream phase source for the waveform processor: generates the 8-bit `cnt` phase ramp that every waveform generator consumes, at a programmable rate, and presents the waveform select to the processor. It is controlled by a start/stop state machine. New divisor and select values are staged and committed only at a period boundary (`cnt` wrapping 255→0), so the processor output never switches shape or frequency mid-period.

## Interface
Parameters:
- `CNT_W`, 8, phase counter width; the `cnt` period is 2^CNT_W ticks.
- `DIV_W`, 8, prescaler divisor width.

Ports:
- `clk`  in  1  single system clock; all logic rising-edge.
- `rst`  in  1  asynchronous, active-low reset (asserted when 0).
- `start`  in  1  level-sampled run request.
- `stop`  in  1  level-sampled stop request; the current period is finished first.
- `div_ld`  in  1  one-cycle strobe; captures `div_in` into the pending divisor.
- `div_in`  in  DIV_W  requested divisor; the tick period is `div_in`+1 clocks.
- `sel_in`  in  3  requested waveform select; sampled every cycle into the pending select.
- `cnt`  out  CNT_W  phase ramp; drives the processor's `cnt`.
- `sel`  out  3  committed waveform select; drives the processor's `sel`.
- `wrap`  out  1  one-cycle pulse in the cycle `cnt` becomes 0 after 255.
- `running`  out  1  high in the RUN and DRAIN states.

## Operation
- Internal registers:
  - `state` ∈ {IDLE, RUN, DRAIN}.
  - `presc` (DIV_W bits).
  - `div_act` and `div_pend` (DIV_W bits).
  - `sel_pend` (3 bits).
- Reset (`rst`=0): all registers and outputs clear immediately.
  - `state`=IDLE.
  - `cnt`=0, `presc`=0, `div_act`=0, `div_pend`=0.
  - `sel`=0, `sel_pend`=0.
  - `wrap`=0, `running`=0.
- Staging, active in every state:
  - `sel_pend` <= `sel_in` every cycle.
  - `div_pend` <= `div_in` when `div_ld`=1.
- Commit: `div_act` <= `div_pend` and `sel` <= `sel_pend`.
  - Commit occurs on the IDLE→RUN transition and on every wrap.
  - Commit uses the pending values held before the current edge. A `div_ld` or `sel_in` change in the same cycle as a commit applies at the next commit.
- Prescaler, in RUN and DRAIN:
  - If `presc`==`div_act`: `presc` <= 0 and `cnt` <= `cnt`+1, modulo 2^CNT_W. This is a tick.
  - Otherwise `presc` <= `presc`+1.
- `wrap` is registered: it is 1 in the cycle after a tick that took `cnt` from 255 to 0, and 0 otherwise.
- FSM transitions:
  - IDLE: `start`=1 and `stop`=0 → RUN, with `cnt`=0, `presc`=0 and a commit. Otherwise remain in IDLE, holding `cnt`=0.
  - RUN: `stop`=1 → DRAIN, even if `start`=1. Otherwise remain in RUN.
  - DRAIN: a wrap tick → IDLE, with `cnt`=0 and no commit. `start`=1 with `stop`=0 → RUN, counting continues uninterrupted. Otherwise remain in DRAIN.
- A wrap tick while in DRAIN takes priority over `start`.
- `stop` in IDLE is ignored.
- `sel` holds its last committed value while in IDLE.

## Timing
- Start latency: `start` sampled at edge N sets `running`=1 and committed `sel`/`div_act` at edge N. `cnt` first becomes 1 at edge N+1+`div_act`.
- Tick period: `div_act`+1 clocks.
- `cnt` period: 256·(`div_act`+1) clocks.
- `div_act`=0: `cnt` increments every clock.
- `div_act`=255: `cnt` increments every 256 clocks.
- `wrap` is high for exactly 1 clock per period. Consecutive `wrap` pulses are 256·(`div_act`+1) clocks apart.
- Stop latency: from `stop`, the block returns to IDLE at the next wrap edge, at most 256·(`div_act`+1) clocks later. The final `wrap` pulse is still produced, coincident with `running` falling.
- A divisor change never shortens or stretches the period in progress.
- Asynchronous reset mid-period: outputs clear without waiting for a clock edge. After `rst` deasserts, the block stays in IDLE until `start`.

## Test plan
- **Reset and start:** reset, then `div_ld` with `div_in`=0, then `start` pulse → `cnt` reads 0,1,2,…,255,0 on consecutive clocks. `wrap`=1 only in the `cnt`=0 cycle; `running`=1 throughout.
- **Prescale:** load `div_in`=3 before `start` → each `cnt` value is held 4 clocks. `wrap` pulses are 1024 clocks apart.
- **Mid-period divisor change:** running with `div`=0, load `div_in`=1 at `cnt`=100 → `cnt` continues 1 per clock until wrap, then 1 per 2 clocks.
- **Mid-period select change:** `sel_in` changes 3→5 at `cnt`=10 → `sel` stays 3 until the wrap cycle, then reads 5. A `sel_in` change in the wrap cycle itself appears only one period later.
- **Stop and drain:** `stop` pulse at `cnt`=200 with `div`=0 → counting continues to 255. `wrap`=1 and `running` falls at `cnt`=0; `cnt` then holds 0. A `start` at `cnt`=230 during DRAIN instead keeps `running`=1 with no gap in counting.
- **Asynchronous reset:** `rst` low at `cnt`=77 between clock edges → `cnt`, `sel`, `running` and `wrap` read 0 immediately. After release, `cnt` holds 0 until `start`.
